// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard stall and branch/jump flush.
// Registers update on the falling clock edge, in step with the other pipeline
// registers. Reset is synchronous and active-high.
// Optional macro IF_ID_PERF_COUNTERS_EN adds saturating 16-bit stall and
// redirect counters on two extra output ports.
//
// state | meaning
// RUN   | normal flow, hazard detection active
// STALL | one-cycle bubble after a load-use stall, hazard detection masked
module if_id_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] IF_ID_PC_Input,
  input  logic [N-1:0] IF_ID_Inst_Input,
  input  logic         ID_EX_MemRead_Input,
  input  logic [4:0]   ID_EX_WriteRegister_Input,
  input  logic         Branch_Taken_Input,
  input  logic         Jump_Input,
  output logic [N-1:0] IF_ID_PC_Output,
  output logic [N-1:0] IF_ID_Inst_Output,
  output logic         IF_ID_Valid_Output,
  output logic         PC_Write_Output,
  output logic         ID_EX_Flush_Output
`ifdef IF_ID_PERF_COUNTERS_EN
  ,
  output logic [15:0]  Stall_Count_Output,
  output logic [15:0]  Flush_Count_Output
`endif
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] inst_q, inst_d;
  logic         valid_q, valid_d;

  logic [4:0] rs;
  logic [4:0] rt;
  logic       hazard;
  logic       redirect;
  logic       stall;

  assign rs       = inst_q[25:21];
  assign rt       = inst_q[20:16];
  assign redirect = Branch_Taken_Input | Jump_Input;

  // Load-use detection; $zero never creates a dependency, STALL masks a repeat.
  always_comb begin
    hazard = ID_EX_MemRead_Input && (ID_EX_WriteRegister_Input != 5'd0) &&
             valid_q && (state_q == RUN) &&
             ((ID_EX_WriteRegister_Input == rs) || (ID_EX_WriteRegister_Input == rt));
    stall  = hazard && !redirect;
  end

  // Next-state and pipeline-control outputs; reset wins, then redirect, then stall.
  always_comb begin
    state_d            = RUN;
    pc_d               = IF_ID_PC_Input;
    inst_d             = IF_ID_Inst_Input;
    valid_d            = 1'b1;
    PC_Write_Output    = 1'b1;
    ID_EX_Flush_Output = 1'b0;
    if (reset) begin
      pc_d    = '0;
      inst_d  = '0;
      valid_d = 1'b0;
    end else if (redirect) begin
      pc_d               = '0;
      inst_d             = '0;
      valid_d            = 1'b0;
      ID_EX_Flush_Output = 1'b1;
    end else if (stall) begin
      state_d            = STALL;
      pc_d               = pc_q;
      inst_d             = inst_q;
      valid_d            = valid_q;
      PC_Write_Output    = 1'b0;
      ID_EX_Flush_Output = 1'b1;
    end
  end

  // Pipeline register and FSM state, falling-edge clocked.
  always_ff @(negedge clk) begin
    state_q <= state_d;
    pc_q    <= pc_d;
    inst_q  <= inst_d;
    valid_q <= valid_d;
  end

  assign IF_ID_PC_Output    = pc_q;
  assign IF_ID_Inst_Output  = inst_q;
  assign IF_ID_Valid_Output = valid_q;

`ifdef IF_ID_PERF_COUNTERS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (reset) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && (stall_cnt_q != 16'hFFFF))
        stall_cnt_d = stall_cnt_q + 16'd1;
      if (redirect && (flush_cnt_q != 16'hFFFF))
        flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(negedge clk) begin
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign Stall_Count_Output = stall_cnt_q;
  assign Flush_Count_Output = flush_cnt_q;
`endif

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter N, default 32, giving the PC and instruction datapath width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its falling edge, matching the other pipeline registers.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port IF_ID_PC_Input, input, N bits: PC+4 from fetch.
REQ-005 SHALL have port IF_ID_Inst_Input, input, N bits: fetched instruction.
REQ-006 SHALL have port ID_EX_MemRead_Input, input, 1 bit: MemRead currently held in the ID/EX register.
REQ-007 SHALL have port ID_EX_WriteRegister_Input, input, 5 bits: destination register currently held in the ID/EX register.
REQ-008 SHALL have port Branch_Taken_Input, input, 1 bit: resolved taken branch.
REQ-009 SHALL have port Jump_Input, input, 1 bit: jump redirect.
REQ-010 SHALL have port IF_ID_PC_Output, output, N bits: registered PC+4.
REQ-011 SHALL have port IF_ID_Inst_Output, output, N bits: registered instruction.
REQ-012 SHALL have port IF_ID_Valid_Output, output, 1 bit: 1 when the register holds a real instruction, 0 for a bubble.
REQ-013 SHALL have port PC_Write_Output, output, 1 bit: 1 lets the PC advance; 0 holds it.
REQ-014 SHALL have port ID_EX_Flush_Output, output, 1 bit: drives the ID/EX register flush input.

Function
REQ-015 SHALL extract rs = IF_ID_Inst_Output[25:21] and rt = IF_ID_Inst_Output[20:16].
REQ-016 SHALL define a load-use hazard, combinationally, when all hold: ID_EX_MemRead_Input=1, ID_EX_WriteRegister_Input≠0, IF_ID_Valid_Output=1, state=RUN, and the write register equals rs or rt.
REQ-017 SHALL define redirect as Branch_Taken_Input OR Jump_Input.
REQ-018 SHALL implement a two-state FSM with states RUN and STALL.
REQ-019 SHALL move RUN→STALL on a hazard without redirect; STALL→RUN unconditionally after one cycle.
REQ-020 SHALL, in STALL, mask hazard detection, giving at most one stall cycle per load.
REQ-021 SHALL, on a hazard without redirect: hold the IF/ID contents, drive PC_Write_Output=0, and drive ID_EX_Flush_Output=1.
REQ-022 SHALL, on redirect: load PC and instruction with 0, load Valid with 0, drive PC_Write_Output=1, drive ID_EX_Flush_Output=1, and go to RUN.
REQ-023 SHALL give redirect priority over a hazard in the same cycle.
REQ-024 SHALL otherwise load IF_ID_PC_Input, IF_ID_Inst_Input and Valid=1, with PC_Write_Output=1 and ID_EX_Flush_Output=0; latency is one clock.
REQ-025 SHALL generate PC_Write_Output and ID_EX_Flush_Output combinationally from the current state and inputs.

Reset
REQ-026 SHALL, while reset=1 at a clock edge, clear IF_ID_PC_Output, IF_ID_Inst_Output and IF_ID_Valid_Output to 0 and set the state to RUN.
REQ-027 SHALL drive PC_Write_Output=1 and ID_EX_Flush_Output=0 during reset, and let reset override stall and redirect, including mid-STALL.

Configuration
REQ-028 SHALL, when macro IF_ID_PERF_COUNTERS_EN is defined, add outputs Stall_Count_Output and Flush_Count_Output, 16 bits each, counting hazard-stall cycles and redirect cycles respectively.
REQ-029 SHALL make both counters saturate at 0xFFFF and clear to 0 on reset.
REQ-030 SHALL, when IF_ID_PERF_COUNTERS_EN is undefined, omit these ports and their logic, leaving all other behaviour identical.

Verification
REQ-031 SHALL cover plain flow: PC 0x4 and Inst 0x012A4020 applied; the next edge gives the same outputs, Valid=1, PC_Write=1.
REQ-032 SHALL cover load-use: IF/ID holds rs=9, and ID_EX MemRead=1 with WriteRegister=9. The bench SHALL see PC_Write=0 and Flush=1 for exactly one cycle, IF/ID held, then RUN with PC_Write=1.
REQ-033 SHALL cover $zero exemption: MemRead=1 with WriteRegister=0 and rs=0 gives no stall.
REQ-034 SHALL cover simultaneous events: a hazard together with Branch_Taken=1 gives PC_Write=1 and Flush=1, the next IF/ID=0 with Valid=0, and state RUN.
REQ-035 SHALL cover reset mid-STALL: reset=1 during STALL gives all outputs 0, PC_Write=1, and RUN on the next edge.
REQ-036 SHALL cover counters, with IF_ID_PERF_COUNTERS_EN defined: 3 stalls and 2 jumps give Stall_Count=3 and Flush_Count=2; preloaded 0xFFFF stays at 0xFFFF.
